// File: rtl/adapter_axi_stream_2_block_fifo_if.sv
// Bundles the AXI Stream input and the block FIFO write port of the stream-to-block adapter.
// The slave modport is the adapter's view; the master modport is the producer/FIFO side.
interface adapter_axi_stream_2_block_fifo_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8
);
    logic [3:0]              i_axi_user;
    logic                    i_axi_valid;
    logic                    o_axi_ready;
    logic [DATA_WIDTH-1:0]   i_axi_data;
    logic [STROBE_WIDTH-1:0] i_axi_keep;
    logic                    i_axi_last;
    logic [1:0]              i_block_fifo_rdy;
    logic [1:0]              o_block_fifo_act;
    logic [23:0]             i_block_fifo_size;
    logic                    o_block_fifo_stb;
    logic [DATA_WIDTH:0]     o_block_fifo_data;

    modport slave (
        input  i_axi_user, i_axi_valid, i_axi_data, i_axi_keep, i_axi_last,
        input  i_block_fifo_rdy, i_block_fifo_size,
        output o_axi_ready, o_block_fifo_act, o_block_fifo_stb, o_block_fifo_data
    );

    modport master (
        output i_axi_user, i_axi_valid, i_axi_data, i_axi_keep, i_axi_last,
        output i_block_fifo_rdy, i_block_fifo_size,
        input  o_axi_ready, o_block_fifo_act, o_block_fifo_stb, o_block_fifo_data
    );
endinterface

// File: rtl/adapter_axi_stream_2_block_fifo.sv
// Streams AXI beats into one ping-pong block FIFO buffer at a time, closing the block
// on the last beat or when the buffer is full.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | no buffer owned; grab one as soon as any rdy bit is set
//   ST_READY   | buffer owned; accept beats until last or count == size
//   ST_RELEASE | buffer handed back; one-cycle act-low gap before IDLE
module adapter_axi_stream_2_block_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8
) (
    input  logic                                 i_axi_clk,
    input  logic                                 rst,
    adapter_axi_stream_2_block_fifo_if.slave     bus,
    output logic [31:0]                          o_debug
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READY   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_act;
    logic [1:0]  w_act_next;
    logic [23:0] r_count;
    logic [23:0] w_count_next;
    logic [23:0] w_count_inc;
    logic        w_ready;
    logic        w_stb;
    logic        w_grab;
    logic        w_close_on_stb;
    logic        w_close_empty;
    logic        w_unused;

    assign w_count_inc    = r_count + 24'd1;
    assign w_ready        = (r_state == ST_READY) && (r_act != 2'b00)
                            && (r_count < bus.i_block_fifo_size);
    assign w_stb          = bus.i_axi_valid && w_ready;
    assign w_grab         = (bus.i_block_fifo_rdy != 2'b00) && (r_act == 2'b00);
    assign w_close_on_stb = w_stb && (bus.i_axi_last || (w_count_inc == bus.i_block_fifo_size));
    // Without a strobe the block can still be full, e.g. when size is zero.
    assign w_close_empty  = !w_stb && (r_count >= bus.i_block_fifo_size);

    always_ff @(posedge i_axi_clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_act   <= 2'b00;
            r_count <= 24'd0;
        end else begin
            r_state <= w_state_next;
            r_act   <= w_act_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_grab) w_state_next = ST_READY;
            ST_READY:   if (w_close_on_stb || w_close_empty) w_state_next = ST_RELEASE;
            ST_RELEASE: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_act_next   = r_act;
        w_count_next = r_count;
        case (r_state)
            ST_IDLE: begin
                if (w_grab) begin
                    w_count_next = 24'd0;
                    // Buffer 0 has priority when both are free.
                    w_act_next   = bus.i_block_fifo_rdy[0] ? 2'b01 : 2'b10;
                end
            end
            ST_READY: begin
                if (w_stb) w_count_next = w_count_inc;
                if (w_close_on_stb || w_close_empty) w_act_next = 2'b00;
            end
            default: w_act_next = 2'b00;
        endcase
    end

    assign bus.o_axi_ready       = w_ready;
    assign bus.o_block_fifo_stb  = w_stb;
    assign bus.o_block_fifo_act  = r_act;
    assign bus.o_block_fifo_data = {bus.i_axi_user[0], bus.i_axi_data};

    assign o_debug = {8'd0, r_count[7:0], 5'd0,
                      bus.i_axi_last, bus.i_axi_valid, w_ready,
                      bus.i_block_fifo_rdy, r_act, 2'b00, r_state};

    assign w_unused = ^{bus.i_axi_keep, bus.i_axi_user[3:1]};

endmodule

// File: tb/tb_adapter_axi_stream_2_block_fifo.sv
// Directed bench for the stream-to-block adapter: a cycle table for the simple blocks,
// plus hand-written sequences for block overflow, valid gaps and mid-block reset.
module tb_adapter_axi_stream_2_block_fifo;

    logic        clk;
    logic        rst;
    logic [31:0] debug;
    int          n_cmp;
    int          n_fail;

    adapter_axi_stream_2_block_fifo_if #(.DATA_WIDTH(32)) bus ();

    adapter_axi_stream_2_block_fifo #(.DATA_WIDTH(32)) dut (
        .i_axi_clk (clk),
        .rst       (rst),
        .bus       (bus),
        .o_debug   (debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rdy;
        logic [23:0] size;
        logic        valid;
        logic        last;
        logic        user;
        logic [31:0] data;
        logic [3:0]  e_state;
        logic [1:0]  e_act;
        logic        e_ready;
        logic        e_stb;
        logic [7:0]  e_count;
    } vec_t;

    vec_t tv[17];

    function automatic vec_t mk(input logic [1:0] rdy, input logic [23:0] size,
                                input logic valid, input logic last, input logic user,
                                input logic [31:0] data, input logic [3:0] e_state,
                                input logic [1:0] e_act, input logic e_ready,
                                input logic e_stb, input logic [7:0] e_count);
        vec_t v;
        v.rdy = rdy; v.size = size; v.valid = valid; v.last = last; v.user = user;
        v.data = data; v.e_state = e_state; v.e_act = e_act; v.e_ready = e_ready;
        v.e_stb = e_stb; v.e_count = e_count;
        return v;
    endfunction

    task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and let combinational outputs settle.
    task automatic apply(input logic [1:0] rdy, input logic [23:0] size, input logic valid,
                         input logic last, input logic user, input logic [31:0] data);
        @(negedge clk);
        bus.i_block_fifo_rdy  = rdy;
        bus.i_block_fifo_size = size;
        bus.i_axi_valid       = valid;
        bus.i_axi_last        = last;
        bus.i_axi_user        = {3'b000, user};
        bus.i_axi_data        = data;
        #1;
    endtask

    task automatic chk_cycle(input string tag, input logic [3:0] st, input logic [1:0] act,
                             input logic rdy_o, input logic stb, input logic [7:0] cnt);
        chk({tag, ".state"}, 40'(debug[3:0]), 40'(st));
        chk({tag, ".act"},   40'(bus.o_block_fifo_act), 40'(act));
        chk({tag, ".ready"}, 40'(bus.o_axi_ready), 40'(rdy_o));
        chk({tag, ".stb"},   40'(bus.o_block_fifo_stb), 40'(stb));
        chk({tag, ".count"}, 40'(debug[23:16]), 40'(cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       pat [7];
        int         gap;
        int         cnt;
        logic [1:0] st_idle, st_ready, st_rel;

        n_cmp  = 0;
        n_fail = 0;
        st_idle = 2'd0; st_ready = 2'd1; st_rel = 2'd2;

        // Test 1: size 4, 4 beats, last on beat 4
        tv[0]  = mk(2'b01, 24'd4, 1'b0, 1'b0, 1'b0, 32'h0,   4'd0, 2'b00, 1'b0, 1'b0, 8'd0);
        tv[1]  = mk(2'b01, 24'd4, 1'b1, 1'b0, 1'b0, 32'h0,   4'd1, 2'b01, 1'b1, 1'b1, 8'd0);
        tv[2]  = mk(2'b01, 24'd4, 1'b1, 1'b0, 1'b0, 32'h1,   4'd1, 2'b01, 1'b1, 1'b1, 8'd1);
        tv[3]  = mk(2'b01, 24'd4, 1'b1, 1'b0, 1'b0, 32'h2,   4'd1, 2'b01, 1'b1, 1'b1, 8'd2);
        tv[4]  = mk(2'b01, 24'd4, 1'b1, 1'b1, 1'b0, 32'h3,   4'd1, 2'b01, 1'b1, 1'b1, 8'd3);
        tv[5]  = mk(2'b00, 24'd4, 1'b0, 1'b0, 1'b0, 32'h0,   4'd2, 2'b00, 1'b0, 1'b0, 8'd4);
        tv[6]  = mk(2'b00, 24'd4, 1'b0, 1'b0, 1'b0, 32'h0,   4'd0, 2'b00, 1'b0, 1'b0, 8'd4);
        // Test 3: size 16, 3 beats, user[0] on the first word only
        tv[7]  = mk(2'b01, 24'd16, 1'b1, 1'b0, 1'b1, 32'hAA,  4'd0, 2'b00, 1'b0, 1'b0, 8'd4);
        tv[8]  = mk(2'b01, 24'd16, 1'b1, 1'b0, 1'b1, 32'h100, 4'd1, 2'b01, 1'b1, 1'b1, 8'd0);
        tv[9]  = mk(2'b01, 24'd16, 1'b1, 1'b0, 1'b0, 32'h101, 4'd1, 2'b01, 1'b1, 1'b1, 8'd1);
        tv[10] = mk(2'b01, 24'd16, 1'b1, 1'b1, 1'b0, 32'h102, 4'd1, 2'b01, 1'b1, 1'b1, 8'd2);
        tv[11] = mk(2'b00, 24'd16, 1'b0, 1'b0, 1'b0, 32'h0,   4'd2, 2'b00, 1'b0, 1'b0, 8'd3);
        tv[12] = mk(2'b00, 24'd16, 1'b0, 1'b0, 1'b0, 32'h0,   4'd0, 2'b00, 1'b0, 1'b0, 8'd3);
        // Test 5: size 0 -> act for one cycle, no strobe
        tv[13] = mk(2'b01, 24'd0, 1'b1, 1'b0, 1'b0, 32'h7,   4'd0, 2'b00, 1'b0, 1'b0, 8'd3);
        tv[14] = mk(2'b00, 24'd0, 1'b1, 1'b0, 1'b0, 32'h7,   4'd1, 2'b01, 1'b0, 1'b0, 8'd0);
        tv[15] = mk(2'b00, 24'd0, 1'b1, 1'b0, 1'b0, 32'h7,   4'd2, 2'b00, 1'b0, 1'b0, 8'd0);
        tv[16] = mk(2'b00, 24'd0, 1'b0, 1'b0, 1'b0, 32'h0,   4'd0, 2'b00, 1'b0, 1'b0, 8'd0);

        rst = 1'b1;
        bus.i_block_fifo_rdy  = 2'b01;
        bus.i_block_fifo_size = 24'd4;
        bus.i_axi_valid       = 1'b1;
        bus.i_axi_last        = 1'b0;
        bus.i_axi_user        = 4'h0;
        bus.i_axi_data        = 32'h0;
        bus.i_axi_keep        = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk_cycle("reset", 4'd0, 2'b00, 1'b0, 1'b0, 8'd0);

        @(negedge clk);
        rst = 1'b0;
        bus.i_block_fifo_rdy = 2'b00;
        bus.i_axi_valid      = 1'b0;

        for (int i = 0; i < 17; i++) begin
            apply(tv[i].rdy, tv[i].size, tv[i].valid, tv[i].last, tv[i].user, tv[i].data);
            chk_cycle($sformatf("vec%0d", i), tv[i].e_state, tv[i].e_act, tv[i].e_ready,
                      tv[i].e_stb, tv[i].e_count);
            if (tv[i].e_stb)
                chk($sformatf("vec%0d.data", i), 40'(bus.o_block_fifo_data),
                    40'({tv[i].user, tv[i].data}));
        end

        // Test 2: 10-beat packet across two size-8 blocks
        apply(2'b11, 24'd8, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t2.idle_act", 40'(bus.o_block_fifo_act), 40'(2'b00));
        for (int b = 0; b < 8; b++) begin
            apply(2'b10, 24'd8, 1'b1, 1'b0, 1'b0, 32'h200 + b);
            chk($sformatf("t2.a%0d.act", b), 40'(bus.o_block_fifo_act), 40'(2'b01));
            chk($sformatf("t2.a%0d.stb", b), 40'(bus.o_block_fifo_stb), 40'(1'b1));
            chk($sformatf("t2.a%0d.count", b), 40'(debug[23:16]), 40'(b));
            chk($sformatf("t2.a%0d.data", b), 40'(bus.o_block_fifo_data), 40'(32'h200 + b));
        end
        gap = 0;
        apply(2'b10, 24'd8, 1'b1, 1'b0, 1'b0, 32'h208);
        while (!bus.o_axi_ready && gap < 6) begin
            gap++;
            apply(2'b10, 24'd8, 1'b1, 1'b0, 1'b0, 32'h208);
        end
        chk("t2.gap", 40'(gap), 40'd2);
        chk("t2.b8.act", 40'(bus.o_block_fifo_act), 40'(2'b10));
        chk("t2.b8.stb", 40'(bus.o_block_fifo_stb), 40'(1'b1));
        chk("t2.b8.count", 40'(debug[23:16]), 40'd0);
        chk("t2.b8.data", 40'(bus.o_block_fifo_data), 40'(32'h208));
        apply(2'b00, 24'd8, 1'b1, 1'b1, 1'b0, 32'h209);
        chk("t2.b9.stb", 40'(bus.o_block_fifo_stb), 40'(1'b1));
        chk("t2.b9.count", 40'(debug[23:16]), 40'd1);
        apply(2'b00, 24'd8, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t2.rel.state", 40'(debug[3:0]), 40'(st_rel));
        chk("t2.rel.act", 40'(bus.o_block_fifo_act), 40'(2'b00));
        apply(2'b00, 24'd8, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t2.idle.state", 40'(debug[3:0]), 40'(st_idle));

        // Test 4: valid toggling 1,0,0,1,1,0,1 into a size-4 block
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        pat[4] = 1'b1; pat[5] = 1'b0; pat[6] = 1'b1;
        apply(2'b01, 24'd4, 1'b0, 1'b0, 1'b0, 32'h0);
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            apply(2'b00, 24'd4, pat[i], 1'b0, 1'b0, 32'h40 + i);
            chk($sformatf("t4.c%0d.act", i), 40'(bus.o_block_fifo_act), 40'(2'b01));
            chk($sformatf("t4.c%0d.stb", i), 40'(bus.o_block_fifo_stb), 40'(pat[i]));
            chk($sformatf("t4.c%0d.count", i), 40'(debug[23:16]), 40'(cnt));
            if (pat[i]) begin
                chk($sformatf("t4.c%0d.data", i), 40'(bus.o_block_fifo_data), 40'(32'h40 + i));
                cnt++;
            end
        end
        apply(2'b00, 24'd4, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t4.rel.state", 40'(debug[3:0]), 40'(st_rel));
        chk("t4.rel.count", 40'(debug[23:16]), 40'd4);
        apply(2'b00, 24'd4, 1'b0, 1'b0, 1'b0, 32'h0);

        // Test 6: reset after two words of a size-8 block
        apply(2'b01, 24'd8, 1'b0, 1'b0, 1'b0, 32'h0);
        apply(2'b00, 24'd8, 1'b1, 1'b0, 1'b0, 32'h500);
        chk("t6.w0.count", 40'(debug[23:16]), 40'd0);
        apply(2'b00, 24'd8, 1'b1, 1'b0, 1'b0, 32'h501);
        chk("t6.w1.count", 40'(debug[23:16]), 40'd1);
        @(negedge clk);
        rst = 1'b1;
        bus.i_axi_data = 32'h502;
        @(negedge clk); #1;
        chk("t6.rst.state", 40'(debug[3:0]), 40'(st_idle));
        chk("t6.rst.act", 40'(bus.o_block_fifo_act), 40'(2'b00));
        chk("t6.rst.count", 40'(debug[23:16]), 40'd0);
        chk("t6.rst.ready", 40'(bus.o_axi_ready), 40'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        bus.i_block_fifo_rdy = 2'b10;
        bus.i_axi_valid      = 1'b0;
        #1;
        chk("t6.idle.act", 40'(bus.o_block_fifo_act), 40'(2'b00));
        apply(2'b10, 24'd8, 1'b1, 1'b0, 1'b0, 32'h600);
        chk("t6.new.state", 40'(debug[3:0]), 40'(st_ready));
        chk("t6.new.act", 40'(bus.o_block_fifo_act), 40'(2'b10));
        chk("t6.new.stb", 40'(bus.o_block_fifo_stb), 40'(1'b1));
        chk("t6.new.count", 40'(debug[23:16]), 40'd0);
        chk("t6.new.data", 40'(bus.o_block_fifo_data), 40'(32'h600));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/adapter_axi_stream_2_block_fifo.md
Name: adapter_axi_stream_2_block_fifo

Overview:
- Converts an incoming AXI Stream into writes to a ping-pong block FIFO write interface.
- Owns the write side of the FIFO.
- Acquires a free buffer and fills it with up to i_block_fifo_size words.
- Releases the buffer early when the stream asserts last, so packet boundaries map onto block boundaries.
- Sits between a streaming producer (video/ADC core) and a clock-crossing block FIFO that a downstream reader drains.

Parameters:
- DATA_WIDTH, 32, width of the AXI data bus and of the FIFO payload (excluding the user bit).
- STROBE_WIDTH, DATA_WIDTH / 8, width of the keep bus. Carried for interface symmetry and unused internally.

Ports:
- i_axi_clk  in  1  clock for all logic.
- rst  in  1  reset, synchronous, active-high.
- i_axi_user  in  4  stream sideband; only bit 0 (start-of-frame) is captured.
- i_axi_valid  in  1  stream data valid.
- o_axi_ready  out  1  adapter can accept the current beat.
- i_axi_data  in  DATA_WIDTH  stream data.
- i_axi_keep  in  STROBE_WIDTH  byte enables; ignored.
- i_axi_last  in  1  final beat of a packet.
- i_block_fifo_rdy  in  2  per-buffer "empty buffer available" flags.
- o_block_fifo_act  out  2  one-hot buffer ownership; at most one bit high.
- i_block_fifo_size  in  24  capacity of a buffer, in words.
- o_block_fifo_stb  out  1  write strobe, one word per cycle.
- o_block_fifo_data  out  DATA_WIDTH+1  {user[0], data}.
- o_debug  out  32  observation bus.

Behaviour:

Reset:
- rst is synchronous and active-high, sampled on the i_axi_clk edge.
- While in reset: state=IDLE, o_block_fifo_act=0, r_count=0.
- Because these registers are reset, o_axi_ready=0 and o_block_fifo_stb=0 from the first post-reset cycle.

Combinational outputs:
- o_axi_ready = (state==READY) && (o_block_fifo_act!=0) && (r_count < i_block_fifo_size).
- o_block_fifo_stb = i_axi_valid && o_axi_ready. A transfer occurs exactly on a cycle with stb=1.
- o_block_fifo_data = {i_axi_user[0], i_axi_data}. Zero latency; the FIFO samples it on stb.

r_count:
- 24-bit counter of words written into the current buffer.
- Increments by 1 per stb. Cannot wrap, because ready drops at r_count==size.

State machine:
- IDLE:
  - If i_block_fifo_rdy!=0 and act==0: r_count<=0; go to READY.
  - Buffer select: act<=2'b01 if rdy[0], else act<=2'b10. Buffer 0 wins when both are ready.
  - Otherwise stay in IDLE with act=0.
- READY, on a stb cycle:
  - r_count<=r_count+1.
  - If i_axi_last==1 or r_count+1==i_block_fifo_size: act<=0 and go to RELEASE.
  - Whichever condition hits first closes the block; the word carrying last is written.
- READY, not on a stb cycle:
  - If r_count>=i_block_fifo_size (covers size==0): act<=0 and go to RELEASE with no strobe issued.
- RELEASE: one cycle with act=0, then go to IDLE. This guarantees an act low gap of at least 2 cycles between blocks.

Latency:
- rdy seen in IDLE → act high on the next edge.
- o_axi_ready rises in the same cycle act is high.
- Sustained throughput is 1 word/cycle within a block.
- Inter-block overhead is 2 dead cycles (RELEASE, IDLE), during which o_axi_ready=0.

Boundary conditions:
- Packet longer than size: the block closes at size. The remainder continues into the next buffer; i_axi_last still terminates that later block.
- last on beat 1: a 1-word block is released.
- valid low mid-block: no strobe and no count change; act is held indefinitely.
- i_block_fifo_size is sampled live and must be stable while act!=0.
- Reset mid-block: act drops on the reset edge and the partially filled buffer is abandoned to the FIFO's own reset. After reset deasserts, the adapter starts over in IDLE.
- The adapter never asserts act for a buffer whose rdy bit was low when it was selected in IDLE.

o_debug:
- [3:0] state.
- [5:4] act.
- [7:6] rdy.
- [8] o_axi_ready.
- [9] i_axi_valid.
- [10] i_axi_last.
- [15:11] 0.
- [23:16] r_count[7:0].
- [31:24] 0.

Test Plan:
1. rdy=2'b01, size=4, 4 beats valid every cycle, last on beat 4 → act=01 for 4 stb cycles, data words 0..3 written in order, then act=00, RELEASE→IDLE, r_count ends at 4.
2. rdy=2'b11, size=8, 10-beat packet with last on beat 10 → block A: act=01, 8 stb, released; block B: act=10 (rdy[0] dropped), 2 stb, released on last; ready low for exactly 2 cycles between blocks.
3. size=16, 3-beat packet with last on beat 3, user[0]=1 on beat 1 → 3 stb cycles; o_block_fifo_data[DATA_WIDTH]=1 on word 0 only; act released after word 2.
4. Valid toggling 1,0,0,1,1,0,1 with size=4 → stb only on valid cycles; count 0→4 across 7 cycles; no word dropped or duplicated; release after the 4th stb.
5. size=0, rdy=01 → act high for exactly 1 cycle, zero stb, then RELEASE→IDLE.
6. rst asserted after the 2nd word of a size-8 block → next edge: act=0, state=IDLE, r_count=0, ready=0; after rst deasserts with rdy=10, a new block starts on buffer 1 at word 0.
